// File: rtl/trigger_out_shaper.sv
// Conditions the single-cycle trigger pulse: programmable delay, pulse width and
// re-arm holdoff, optional inversion, plus saturating accepted/missed counters.
module trigger_out_shaper #(
    parameter int CNT_W  = 16,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              trig_in,
    input  logic              cfg_enable,
    input  logic [7:0]        cfg_delay,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_holdoff,
    input  logic              cfg_invert,
    input  logic              cfg_clear_count,
    output logic              shaped_out,
    output logic              busy,
    output logic [CNT_W-1:0]  trig_count,
    output logic [MISS_W-1:0] missed_count
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          wm1_q, wm1_d;
    logic [7:0]          hold_q, hold_d;
    logic [CNT_W-1:0]    trig_cnt_q, trig_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                shaped_q, busy_q;
    logic                accept, miss;

    assign accept = (state_q == IDLE) && cfg_enable && trig_in;
    assign miss   = (state_q != IDLE) && cfg_enable && trig_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wm1_d   = wm1_q;
        hold_d  = hold_q;
        if (!cfg_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_in) begin
                        // Width and holdoff are captured now so later cfg writes cannot stretch this event.
                        wm1_d  = (cfg_width == 8'd0) ? 8'd0 : cfg_width - 8'd1;
                        hold_d = cfg_holdoff;
                        if (cfg_delay != 8'd0) begin
                            state_d = DELAY;
                            cnt_d   = cfg_delay - 8'd1;
                        end else begin
                            state_d = PULSE;
                            cnt_d   = wm1_d;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == 8'd0) begin
                        state_d = PULSE;
                        cnt_d   = wm1_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 8'd0) begin
                        if (hold_q != 8'd0) begin
                            state_d = HOLDOFF;
                            cnt_d   = hold_q - 8'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    if (cnt_q == 8'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        trig_cnt_d = trig_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cfg_clear_count) begin
            trig_cnt_d = '0;
            miss_cnt_d = '0;
        end else begin
            if (accept && (trig_cnt_q != {CNT_W{1'b1}}))  trig_cnt_d = trig_cnt_q + CNT_W'(1);
            if (miss && (miss_cnt_q != {MISS_W{1'b1}}))   miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            wm1_q      <= 8'd0;
            hold_q     <= 8'd0;
            trig_cnt_q <= '0;
            miss_cnt_q <= '0;
            shaped_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wm1_q      <= wm1_d;
            hold_q     <= hold_d;
            trig_cnt_q <= trig_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            shaped_q   <= (state_d == PULSE) ^ cfg_invert;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign shaped_out   = shaped_q;
    assign busy         = busy_q;
    assign trig_count   = trig_cnt_q;
    assign missed_count = miss_cnt_q;

endmodule

// File: tb/tb_trigger_out_shaper.sv
// Bench for trigger_out_shaper: event-window reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trigger_out_shaper;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        trig_in = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [7:0]  cfg_delay = 8'd0;
    logic [7:0]  cfg_width = 8'd1;
    logic [7:0]  cfg_holdoff = 8'd0;
    logic        cfg_invert = 1'b0;
    logic        cfg_clear_count = 1'b0;
    logic        shaped_out, busy;
    logic [15:0] trig_count;
    logic [7:0]  missed_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    trigger_out_shaper #(.CNT_W(16), .MISS_W(8)) dut (
        .clk(clk), .rst_sync(rst_sync), .trig_in(trig_in), .cfg_enable(cfg_enable),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_holdoff(cfg_holdoff),
        .cfg_invert(cfg_invert), .cfg_clear_count(cfg_clear_count),
        .shaped_out(shaped_out), .busy(busy), .trig_count(trig_count), .missed_count(missed_count)
    );

    always #5 clk = ~clk;

    // Reference: each accepted trigger at cycle t defines a pulse window and a busy window.
    longint cyc = 0, m_ps = 0, m_pe = -1, m_be = -1;
    int     m_tc = 0, m_mc = 0;
    bit     exp_out = 1'b0, exp_busy = 1'b0;
    longint n_ps, n_pe, n_be, nxt, wv;
    int     n_tc, n_mc;
    bit     idle_m, acc_m, mis_m, n_out, n_busy;

    always_comb begin
        nxt    = cyc + 1;
        idle_m = cyc > m_be;
        acc_m  = !rst_sync && cfg_enable && trig_in && idle_m;
        mis_m  = !rst_sync && cfg_enable && trig_in && !idle_m;
        n_ps = m_ps; n_pe = m_pe; n_be = m_be;
        wv = (cfg_width == 8'd0) ? 64'd1 : longint'(cfg_width);
        if (rst_sync || !cfg_enable) begin
            n_ps = 0; n_pe = -1; n_be = cyc;
        end else if (acc_m) begin
            n_ps = cyc + 1 + longint'(cfg_delay);
            n_pe = cyc + longint'(cfg_delay) + wv;
            n_be = cyc + longint'(cfg_delay) + wv + longint'(cfg_holdoff);
        end
        n_busy = !rst_sync && (nxt <= n_be);
        n_out  = rst_sync ? 1'b0 : (((n_ps <= nxt) && (nxt <= n_pe)) ^ cfg_invert);
        if (rst_sync || cfg_clear_count) begin
            n_tc = 0; n_mc = 0;
        end else begin
            n_tc = (acc_m && m_tc < 65535) ? m_tc + 1 : m_tc;
            n_mc = (mis_m && m_mc < 255)   ? m_mc + 1 : m_mc;
        end
    end

    always @(posedge clk) begin
        cyc      <= nxt;
        m_ps     <= n_ps;
        m_pe     <= n_pe;
        m_be     <= n_be;
        m_tc     <= n_tc;
        m_mc     <= n_mc;
        exp_out  <= n_out;
        exp_busy <= n_busy;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Advances one clock and compares every DUT output with the model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("model_shaped_out", int'(shaped_out), int'(exp_out));
            check("model_busy", int'(busy), int'(exp_busy));
            check("model_trig_count", int'(trig_count), m_tc);
            check("model_missed_count", int'(missed_count), m_mc);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) tick();
        check("idle_wait_timeout", int'(busy), 0);
    endtask

    task automatic clear_counts();
        cfg_clear_count = 1'b1;
        tick();
        cfg_clear_count = 1'b0;
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_shaped_out", int'(shaped_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_count", int'(trig_count), 0);
        check("reset_missed_count", int'(missed_count), 0);
        rst_sync = 1'b0;
        tick(); tick();

        // d=0 w=1 h=0: single-cycle pulse in cycle 1
        trig_in = 1'b1;
        tick();
        check("t1_shaped_c1", int'(shaped_out), 1);
        check("t1_busy_c1", int'(busy), 1);
        trig_in = 1'b0;
        tick();
        check("t1_shaped_c2", int'(shaped_out), 0);
        check("t1_busy_c2", int'(busy), 0);
        check("t1_trig_count", int'(trig_count), 1);

        // d=3 w=4 h=2: triggers at cycles 0, 5 (missed), 10
        clear_counts();
        cfg_delay = 8'd3; cfg_width = 8'd4; cfg_holdoff = 8'd2;
        for (int c = 0; c < 21; c++) begin
            trig_in = (c == 0 || c == 5 || c == 10);
            tick();
            check("t2_shaped", int'(shaped_out),
                  int'((c+1 >= 4 && c+1 <= 7) || (c+1 >= 14 && c+1 <= 17)));
            check("t2_busy", int'(busy),
                  int'((c+1 >= 1 && c+1 <= 9) || (c+1 >= 11 && c+1 <= 19)));
        end
        trig_in = 1'b0;
        check("t2_trig_count", int'(trig_count), 2);
        check("t2_missed_count", int'(missed_count), 1);

        // width 0 treated as 1, inverted output, back-to-back acceptance
        cfg_delay = 8'd0; cfg_width = 8'd0; cfg_holdoff = 8'd0; cfg_invert = 1'b1;
        tick();
        check("t3_idle_high", int'(shaped_out), 1);
        for (int c = 0; c < 5; c++) begin
            trig_in = (c == 0 || c == 2);
            tick();
            check("t3_shaped", int'(shaped_out), int'(!(c+1 == 1 || c+1 == 3)));
        end
        trig_in = 1'b0;
        cfg_invert = 1'b0;
        tick();

        // enable dropped in cycle 6 of a d=2 w=10 event
        clear_counts();
        cfg_delay = 8'd2; cfg_width = 8'd10;
        for (int c = 0; c < 10; c++) begin
            trig_in = (c == 0);
            cfg_enable = (c < 6);
            tick();
            if (c + 1 == 6) check("t4_shaped_c6", int'(shaped_out), 1);
            if (c + 1 >= 7) begin
                check("t4_shaped_off", int'(shaped_out), 0);
                check("t4_busy_off", int'(busy), 0);
            end
        end
        check("t4_trig_count", int'(trig_count), 1);
        cfg_enable = 1'b1;
        tick();

        // missed counter saturation, then clear against a simultaneous accept
        cfg_delay = 8'd0; cfg_width = 8'd1; cfg_holdoff = 8'd255;
        trig_in = 1'b1;
        for (int c = 0; c < 300; c++) tick();
        trig_in = 1'b0;
        check("t5_missed_sat", int'(missed_count), 255);
        wait_idle();
        cfg_holdoff = 8'd0;
        trig_in = 1'b1; cfg_clear_count = 1'b1;
        tick();
        trig_in = 1'b0; cfg_clear_count = 1'b0;
        check("t5_clear_trig", int'(trig_count), 0);
        check("t5_clear_missed", int'(missed_count), 0);
        check("t5_clear_accepted", int'(shaped_out), 1);
        wait_idle();

        // reset in the middle of a pulse
        cfg_width = 8'd10;
        for (int c = 0; c < 4; c++) begin
            trig_in = (c == 0);
            rst_sync = (c == 3);
            tick();
        end
        check("t6_rst_shaped", int'(shaped_out), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_count", int'(trig_count), 0);
        rst_sync = 1'b0;
        tick();
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        check("t6_after_shaped", int'(shaped_out), 1);
        check("t6_after_busy", int'(busy), 1);
        check("t6_after_count", int'(trig_count), 1);
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                cfg_delay   = 8'($urandom_range(0, 6));
                cfg_width   = 8'($urandom_range(0, 6));
                cfg_holdoff = 8'($urandom_range(0, 6));
                cfg_invert  = 1'($urandom_range(0, 1));
            end
            trig_in         = ($urandom_range(0, 3) == 0);
            cfg_enable      = ($urandom_range(0, 39) != 0);
            cfg_clear_count = ($urandom_range(0, 99) == 0);
            rst_sync        = ($urandom_range(0, 499) == 0);
            tick();
        end
        trig_in = 1'b0; cfg_clear_count = 1'b0; rst_sync = 1'b0; cfg_enable = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_out_shaper.md
Name: trigger_out_shaper

Overview:
- Downstream stage of the trigger block. Consumes its single-cycle trigger_out pulse and produces the conditioned trigger that drives the FPGA pin to the scope or logic analyser.
- Adds a programmable delay, a programmable output pulse width and a re-arm holdoff. Optional output inversion.
- Counts accepted triggers and triggers dropped while busy, so firmware can read them back through a SCARF regmap.

Parameters:
- CNT_W, 16, width of the accepted-trigger counter (saturating).
- MISS_W, 8, width of the missed-trigger counter (saturating).

Ports:
- clk  input  1  fpga clk (12MHz or 100MHz)
- rst_sync  input  1  synchronous active-high reset
- trig_in  input  1  trigger pulse from the trigger block; any high cycle is one event
- cfg_enable  input  1  shaper enable
- cfg_delay  input  8  cycles from acceptance to output assertion
- cfg_width  input  8  output pulse width in cycles; 0 is treated as 1
- cfg_holdoff  input  8  cycles after the pulse during which trig_in is ignored
- cfg_invert  input  1  1 = active-low output, idle high
- cfg_clear_count  input  1  synchronous clear of both counters
- shaped_out  output  1  conditioned trigger, registered
- busy  output  1  high when state is not IDLE, registered
- trig_count  output  CNT_W  accepted triggers, saturating
- missed_count  output  MISS_W  triggers dropped while busy, saturating

Behaviour:
- Reset (rst_sync high at a clk edge):
  - state=IDLE, all counters 0, busy=0, shaped_out=0.
  - cfg_invert is applied from the first cycle after reset release.
  - Reset mid-operation aborts immediately; no pulse completes.
- States: IDLE, DELAY, PULSE, HOLDOFF. A single 8-bit down-counter is shared by DELAY, PULSE and HOLDOFF.
- Timing, with trig_in high in cycle 0 while in IDLE and cfg_enable=1 (accepted):
  - w = max(cfg_width,1); d = cfg_delay; h = cfg_holdoff, all sampled in cycle 0.
  - Later cfg changes do not affect the current event.
  - Active output level during cycles 1+d .. d+w.
  - busy high during cycles 1 .. d+w+h.
  - IDLE again in cycle d+w+h+1; trig_in in that cycle is accepted.
- Transitions:
  - IDLE -> DELAY if d>0, else IDLE -> PULSE.
  - DELAY -> PULSE when the counter expires.
  - PULSE -> HOLDOFF if h>0, else PULSE -> IDLE.
  - HOLDOFF -> IDLE when the counter expires.
- Output level: shaped_out = pulse_active XOR cfg_invert, registered.
- trig_count: +1 per accepted trigger; holds at 2^CNT_W-1.
- missed_count: +1 for each cycle with trig_in=1 while state != IDLE and cfg_enable=1; holds at 2^MISS_W-1.
- trig_in while cfg_enable=0 is ignored and not counted.
- cfg_enable deasserted in any state: next cycle state=IDLE, busy=0, output at idle level. Counters hold.
- cfg_clear_count=1: both counters are 0 next cycle. Clear wins over a simultaneous increment. The state machine is unaffected.
- A trig_in held high for several cycles: first cycle accepted, the remaining high cycles while busy each count as missed.

Test Plan:
- d=0,w=1,h=0,invert=0; trig_in high cycle 0 -> shaped_out high cycle 1 only, busy high cycle 1, trig_count=1.
- d=3,w=4,h=2; trig_in cycles 0, 5, 10 -> shaped_out high cycles 4..7 and 14..17; busy high 1..9 and 11..19; trig_count=2, missed_count=1.
- cfg_width=0,d=0,h=0; cfg_invert=1 -> idle high, low in cycle 1 only; second trig_in in cycle 2 accepted, low in cycle 3.
- d=2,w=10; cfg_enable dropped in cycle 6 -> shaped_out low and busy low from cycle 7; trig_count=1 retained.
- 300 trig_in cycles during a long holdoff -> missed_count=255; cfg_clear_count with a simultaneous accepted trig_in -> both counters 0 next cycle.
- rst_sync asserted mid-PULSE -> next cycle shaped_out=0, busy=0, counters 0; a trigger after release behaves as from IDLE.
